ibex_pmp_csr: RTL

- Machine-mode CSR register file for Physical Memory Protection (PMP).
- Owns the pmpcfg, pmpaddr and mseccfg state, applies the WARL/lock legalisation rules, and serves CSR reads and writes over a simple request/response handshake.
- Drives the packed cfg, addr and mseccfg buses consumed by the core's PMP access checker.
- Sits between the CSR decode stage and the PMP checker.

---
 rtl/ibex_pmp_csr.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ibex_pmp_csr.sv
// PMP CSR file: pmpcfg/pmpaddr/mseccfg storage, WARL and lock
// legalisation, single-cycle CSR response, packed checker buses.
module ibex_pmp_csr #(
  parameter int PMPGranularity = 0,
  parameter int PMPNumRegions  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         csr_req_i,
  input  logic                         csr_we_i,
  input  logic [11:0]                  csr_addr_i,
  input  logic [31:0]                  csr_wdata_i,
  output logic                         csr_rvalid_o,
  output logic [31:0]                  csr_rdata_o,
  output logic                         csr_err_o,
  output logic                         pmp_update_o,
  output logic [PMPNumRegions*6-1:0]   csr_pmp_cfg_o,
  output logic [PMPNumRegions*34-1:0]  csr_pmp_addr_o,
  output logic [2:0]                   csr_pmp_mseccfg_o
);
  localparam int N = PMPNumRegions;
  localparam int G = PMPGranularity;

  // b is the write byte with bits 6:5 dropped: {L, A, X, W, R}
  function automatic logic [5:0] f_legal(
    input logic [5:0] old,
    input logic [5:0] b,
    input logic       mml,
    input logic       rlb
  );
    logic [5:0] n;
    n = b;
    if (G >= 1 && b[4:3] == 2'b10) n[4:3] = old[4:3];
    if (!mml && b[1:0] == 2'b10) n[1:0] = 2'b00;
    if (old[5] && !rlb) n = old;
    else if (mml && !rlb && b[5] &&
             (b[2] || b[1:0] == 2'b10)) n = old;
    return n;
  endfunction

  // Granule-aligned read view; raw storage keeps all 32 bits
  function automatic logic [31:0] f_view(
    input logic [31:0] a,
    input logic [1:0]  mode
  );
    logic [31:0] v;
    v = a;
    for (int k = 0; k < 32; k++) begin
      if (mode == 2'b11 && k < G - 1) v[k] = 1'b1;
      else if (!mode[1] && k < G) v[k] = 1'b0;
    end
    return v;
  endfunction

  logic [5:0]  r_cfg [N];
  logic [31:0] r_addr [N];
  logic [2:0]  r_msec;
  logic        r_rvalid;
  logic        r_err;
  logic        r_upd;
  logic [11:0] r_raddr;

  logic [5:0]  w_cfg_d [N];
  logic [31:0] w_addr_d [N];
  logic [2:0]  w_msec_d;
  logic        w_nxt_lock [N];
  logic        w_any_lock;
  logic        w_wr;
  logic        w_is_cfg;
  logic        w_is_addr;
  logic        w_is_msec;
  logic        w_is_msech;
  logic        w_hit;
  logic        w_upd;
  logic [31:0] w_rdata;

  always_comb begin
    w_is_cfg   = csr_addr_i[11:2] == 10'h0E8;
    w_is_addr  = csr_addr_i[11:4] == 8'h3B;
    w_is_msec  = csr_addr_i == 12'h747;
    w_is_msech = csr_addr_i == 12'h757;
    w_hit      = w_is_cfg | w_is_addr | w_is_msec | w_is_msech;
    w_wr       = csr_req_i & csr_we_i;
  end

  // A locked TOR entry also freezes the address below it
  always_comb begin
    w_any_lock = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_nxt_lock[i] = 1'b0;
      w_any_lock    = w_any_lock | r_cfg[i][5];
    end
    for (int i = 0; i < N - 1; i++) begin
      w_nxt_lock[i] = r_cfg[i+1][5] &&
                      r_cfg[i+1][4:3] == 2'b01;
    end
  end

  always_comb begin
    w_msec_d = r_msec;
    for (int i = 0; i < N; i++) begin
      w_cfg_d[i]  = r_cfg[i];
      w_addr_d[i] = r_addr[i];
      if (w_wr && w_is_cfg &&
          csr_addr_i[1:0] == 2'(i / 4)) begin
        w_cfg_d[i] = f_legal(
          r_cfg[i],
          {csr_wdata_i[(i%4)*8+7],
           csr_wdata_i[(i%4)*8 +: 5]},
          r_msec[0], r_msec[2]);
      end
      if (w_wr && w_is_addr &&
          csr_addr_i[3:0] == 4'(i) &&
          !(!r_msec[2] &&
            (r_cfg[i][5] || w_nxt_lock[i]))) begin
        w_addr_d[i] = csr_wdata_i;
      end
    end
    if (w_wr && w_is_msec) begin
      w_msec_d[0] = r_msec[0] | csr_wdata_i[0];
      w_msec_d[1] = r_msec[1] | csr_wdata_i[1];
      if (r_msec[2] || !w_any_lock)
        w_msec_d[2] = csr_wdata_i[2];
    end
    w_upd = w_msec_d != r_msec;
    for (int i = 0; i < N; i++) begin
      if (w_cfg_d[i] != r_cfg[i] ||
          f_view(w_addr_d[i], w_cfg_d[i][4:3]) !=
          f_view(r_addr[i], r_cfg[i][4:3]))
        w_upd = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) begin
        r_cfg[i]  <= '0;
        r_addr[i] <= '0;
      end
      r_msec   <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_upd    <= 1'b0;
      r_raddr  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        r_cfg[i]  <= w_cfg_d[i];
        r_addr[i] <= w_addr_d[i];
      end
      r_msec   <= w_msec_d;
      r_rvalid <= csr_req_i;
      r_err    <= csr_req_i & ~w_hit;
      r_upd    <= w_upd;
      r_raddr  <= csr_addr_i;
    end
  end

  // Read data comes from the post-write state in the response cycle
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < N; i++) begin
      if (r_raddr[11:2] == 10'h0E8 &&
          r_raddr[1:0] == 2'(i / 4))
        w_rdata[(i%4)*8 +: 8] =
          {r_cfg[i][5], 2'b00, r_cfg[i][4:0]};
      if (r_raddr[11:4] == 8'h3B &&
          r_raddr[3:0] == 4'(i))
        w_rdata = f_view(r_addr[i], r_cfg[i][4:3]);
    end
    if (r_raddr == 12'h747) w_rdata = {29'd0, r_msec};
  end

  assign csr_rvalid_o      = r_rvalid;
  assign csr_rdata_o       = r_rvalid ? w_rdata : '0;
  assign csr_err_o         = r_err;
  assign pmp_update_o      = r_upd;
  assign csr_pmp_mseccfg_o = r_msec;

  for (genvar r = 0; r < N; r++) begin : g_out
    assign csr_pmp_cfg_o[(N-1-r)*6 +: 6] = r_cfg[r];
    assign csr_pmp_addr_o[(N-1-r)*34 +: 34] =
      {f_view(r_addr[r], r_cfg[r][4:3]), 2'b00};
  end

endmodule
